// File: rtl/midi_pkg.sv
// Shared MIDI constants and UART state encoding for the midi_poly_rx slice.
package midi_pkg;

    localparam logic [3:0] ST_NOTE_OFF = 4'h8;
    localparam logic [3:0] ST_NOTE_ON  = 4'h9;
    localparam logic [3:0] ST_POLY_AT  = 4'hA;
    localparam logic [3:0] ST_CC       = 4'hB;
    localparam logic [3:0] ST_PITCH    = 4'hE;

    localparam logic [6:0] CC_SUSTAIN       = 7'd64;
    localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/midi_uart_rx.sv
// MIDI line deserialiser: 2-FF synchroniser, bit timer and IDLE/START/DATA/STOP FSM.
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int unsigned BIT_PERIOD = 3200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_in,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       framing_err
);

    localparam int unsigned HALF_PERIOD = BIT_PERIOD / 2;
    localparam int unsigned CNT_W       = $clog2(BIT_PERIOD + 1);

    uart_state_t      state, state_nxt;
    logic [1:0]       sync_q;
    logic             rx_s;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shreg_q;
    logic             half_tick_c, bit_tick_c;
    logic             cnt_clr_c, shift_c, valid_c, ferr_c;

    assign rx_s        = sync_q[1];
    assign half_tick_c = (cnt_q == CNT_W'(HALF_PERIOD - 1));
    assign bit_tick_c  = (cnt_q == CNT_W'(BIT_PERIOD - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= UART_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            UART_IDLE:  if (!rx_s) state_nxt = UART_START;
            UART_START: if (half_tick_c) state_nxt = rx_s ? UART_IDLE : UART_DATA;
            UART_DATA:  if (bit_tick_c && (bit_idx_q == 3'd7)) state_nxt = UART_STOP;
            UART_STOP:  if (bit_tick_c) state_nxt = UART_IDLE;
            default:    state_nxt = UART_IDLE;
        endcase
    end

    // Per-state strobes for the bit timer, shifter and result pulses
    always_comb begin
        cnt_clr_c = 1'b0;
        shift_c   = 1'b0;
        valid_c   = 1'b0;
        ferr_c    = 1'b0;
        case (state)
            UART_IDLE:  cnt_clr_c = 1'b1;
            UART_START: cnt_clr_c = half_tick_c;
            UART_DATA: begin
                cnt_clr_c = bit_tick_c;
                shift_c   = bit_tick_c;
            end
            UART_STOP: begin
                cnt_clr_c = bit_tick_c;
                valid_c   = bit_tick_c && rx_s;
                ferr_c    = bit_tick_c && !rx_s;
            end
            default: cnt_clr_c = 1'b1;
        endcase
    end

    // Synchroniser, timer, LSB-first shift register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= 2'b11;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            rx_byte     <= '0;
            byte_valid  <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], data_in};
            cnt_q       <= cnt_clr_c ? '0 : cnt_q + CNT_W'(1);
            if (state != UART_DATA) bit_idx_q <= '0;
            else if (shift_c)       bit_idx_q <= bit_idx_q + 3'd1;
            if (shift_c) shreg_q <= {rx_s, shreg_q[7:1]};
            if (valid_c) rx_byte <= shreg_q;
            byte_valid  <= valid_c;
            framing_err <= ferr_c;
        end
    end

endmodule

// File: rtl/midi_poly_rx.sv
// MIDI receiver with running-status parser and polyphonic voice allocator.
// Optional sustain pedal (CC64) support is built when SUSTAIN_EN is defined.
module midi_poly_rx
    import midi_pkg::*;
#(
    parameter int unsigned INPUT_CLOCK_FREQ = 100_000_000,
    parameter int unsigned BAUD_RATE        = 31_250,
    parameter int unsigned NUM_VOICES       = 8,
    parameter int unsigned VEL_BITS         = 3,
    parameter int unsigned MIDI_CHANNEL     = 0,
    parameter int unsigned OMNI             = 0,
    localparam int unsigned VIW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           data_in,
    output logic [NUM_VOICES-1:0]          on_out,
    output logic [NUM_VOICES*VEL_BITS-1:0] velocity_out,
    output logic [NUM_VOICES*7-1:0]        note_out,
    output logic                           note_evt,
    output logic [VIW-1:0]                 evt_voice,
    output logic                           framing_err
);

    localparam int unsigned BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;

    logic [7:0] rx_byte;
    logic       byte_valid;

    midi_uart_rx #(.BIT_PERIOD(BIT_PERIOD)) u_uart (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .framing_err(framing_err)
    );

    logic       st_valid_q, idx_q;
    logic [3:0] st_kind_q, st_chan_q;
    logic [6:0] d1_q, d2;
    logic       two_byte_c, chan_ok_c, msg_c;
    logic       note_on_c, note_off_c, all_off_c, rel_c;

    logic [NUM_VOICES-1:0]               on_q, held_vec, off_mask_c, evt_mask_c;
    logic [NUM_VOICES-1:0][6:0]          note_q;
    logic [NUM_VOICES-1:0][VEL_BITS-1:0] vel_q;
    logic [NUM_VOICES-1:0][VIW-1:0]      age_q;
    logic [VEL_BITS-1:0]                 vel_raw, vel_map;
    logic [VIW-1:0]                      match_idx, free_idx, steal_idx, alloc_idx, low_idx;
    logic                                match_hit, free_hit, best_held;
    logic [VIW-1:0]                      best_age;

    assign d2         = rx_byte[6:0];
    assign two_byte_c = st_kind_q inside {ST_NOTE_OFF, ST_NOTE_ON, ST_POLY_AT, ST_CC, ST_PITCH};
    assign chan_ok_c  = (OMNI != 0) || (st_chan_q == 4'(MIDI_CHANNEL));
    assign msg_c      = byte_valid && !rx_byte[7] && st_valid_q && two_byte_c && idx_q && chan_ok_c;
    assign note_on_c  = msg_c && (st_kind_q == ST_NOTE_ON) && (d2 != 7'd0);
    assign note_off_c = msg_c && ((st_kind_q == ST_NOTE_OFF) || ((st_kind_q == ST_NOTE_ON) && (d2 == 7'd0)));
    assign all_off_c  = msg_c && (st_kind_q == ST_CC) && (d1_q == CC_ALL_NOTES_OFF);
    assign vel_raw    = d2[6 -: VEL_BITS];
    assign vel_map    = (vel_raw == '0) ? VEL_BITS'(1) : vel_raw;

`ifdef SUSTAIN_EN
    logic                  sustain_q;
    logic [NUM_VOICES-1:0] held_q;
    logic                  sus_cc_c;
    assign sus_cc_c = msg_c && (st_kind_q == ST_CC) && (d1_q == CC_SUSTAIN);
    assign rel_c    = sus_cc_c && !d2[6];
    assign held_vec = held_q;
`else
    assign rel_c    = 1'b0;
    assign held_vec = '0;
`endif

    assign on_out       = on_q;
    assign note_out     = note_q;
    assign velocity_out = vel_q;

    // Running-status parser: realtime bytes leave status and data index untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            st_valid_q <= 1'b0;
            st_kind_q  <= '0;
            st_chan_q  <= '0;
            idx_q      <= 1'b0;
            d1_q       <= '0;
        end else if (byte_valid) begin
            if (rx_byte[7]) begin
                if (rx_byte[7:4] != 4'hF) begin
                    st_valid_q <= 1'b1;
                    st_kind_q  <= rx_byte[7:4];
                    st_chan_q  <= rx_byte[3:0];
                    idx_q      <= 1'b0;
                end else if (!rx_byte[3]) begin
                    st_valid_q <= 1'b0;
                end
            end else if (st_valid_q && two_byte_c) begin
                if (!idx_q) d1_q <= d2;
                idx_q <= !idx_q;
            end
        end
    end

    // Allocation search: retrigger match, lowest free voice, oldest (held-first) steal
    always_comb begin
        match_hit  = 1'b0;
        match_idx  = '0;
        free_hit   = 1'b0;
        free_idx   = '0;
        off_mask_c = '0;
        steal_idx  = '0;
        best_held  = held_vec[0];
        best_age   = age_q[0];
        for (int i = 0; i < NUM_VOICES; i++) begin
            off_mask_c[i] = on_q[i] && (note_q[i] == d1_q);
            if (off_mask_c[i] && !match_hit) begin
                match_hit = 1'b1;
                match_idx = VIW'(i);
            end
            if (!on_q[i] && !free_hit) begin
                free_hit = 1'b1;
                free_idx = VIW'(i);
            end
            if ({held_vec[i], age_q[i]} > {best_held, best_age}) begin
                best_held = held_vec[i];
                best_age  = age_q[i];
                steal_idx = VIW'(i);
            end
        end
        alloc_idx = match_hit ? match_idx : (free_hit ? free_idx : steal_idx);
    end

    // Lowest voice index among the slots touched by an off-type event
    always_comb begin
        evt_mask_c = on_q;
        if (note_off_c) evt_mask_c = off_mask_c;
        else if (rel_c) evt_mask_c = held_vec;
        low_idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (evt_mask_c[i]) low_idx = VIW'(i);
        end
    end

    // Voice slot registers and note event pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            on_q      <= '0;
            note_q    <= '0;
            vel_q     <= '0;
            age_q     <= '0;
            note_evt  <= 1'b0;
            evt_voice <= '0;
`ifdef SUSTAIN_EN
            sustain_q <= 1'b0;
            held_q    <= '0;
`endif
        end else begin
            note_evt <= 1'b0;
            if (note_on_c) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (VIW'(i) == alloc_idx) begin
                        on_q[i]   <= 1'b1;
                        note_q[i] <= d1_q;
                        vel_q[i]  <= vel_map;
                        age_q[i]  <= '0;
`ifdef SUSTAIN_EN
                        held_q[i] <= 1'b0;
`endif
                    end else if (on_q[i] && (age_q[i] != VIW'(NUM_VOICES - 1))) begin
                        age_q[i] <= age_q[i] + VIW'(1);
                    end
                end
                note_evt  <= 1'b1;
                evt_voice <= alloc_idx;
            end else if (note_off_c) begin
                if (|off_mask_c) begin
`ifdef SUSTAIN_EN
                    if (sustain_q) held_q <= held_q | off_mask_c;
                    else           on_q   <= on_q & ~off_mask_c;
`else
                    on_q <= on_q & ~off_mask_c;
`endif
                    note_evt  <= 1'b1;
                    evt_voice <= low_idx;
                end
            end else if (all_off_c) begin
                if (|on_q) begin
                    on_q      <= '0;
                    note_evt  <= 1'b1;
                    evt_voice <= low_idx;
                end
`ifdef SUSTAIN_EN
                held_q <= '0;
            end else if (sus_cc_c) begin
                sustain_q <= d2[6];
                if (rel_c && (|held_q)) begin
                    on_q      <= on_q & ~held_q;
                    held_q    <= '0;
                    note_evt  <= 1'b1;
                    evt_voice <= low_idx;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_midi_poly_rx.sv
// Bench for midi_poly_rx: directed scenarios plus randomized byte streams checked
// against a rule-level voice model. Sustain scenario is built when SUSTAIN_EN is defined.
module tb_midi_poly_rx;

    localparam int unsigned N    = 8;
    localparam int unsigned VB   = 3;
    localparam int unsigned FREQ = 500_000;
    localparam int unsigned BAUD = 31_250;
    localparam int unsigned BP   = FREQ / BAUD;
    localparam int unsigned VIW  = 3;
`ifdef SUSTAIN_EN
    localparam bit SUS = 1'b1;
`else
    localparam bit SUS = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1, data_in = 1'b1;
    logic [N-1:0]    on_out, o_on_out;
    logic [N*VB-1:0] velocity_out, o_velocity_out;
    logic [N*7-1:0]  note_out, o_note_out;
    logic            note_evt, o_note_evt, framing_err, o_framing_err;
    logic [VIW-1:0]  evt_voice, o_evt_voice;

    midi_poly_rx #(.INPUT_CLOCK_FREQ(FREQ), .BAUD_RATE(BAUD), .NUM_VOICES(N), .VEL_BITS(VB),
                   .MIDI_CHANNEL(0), .OMNI(0)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .on_out(on_out), .velocity_out(velocity_out),
        .note_out(note_out), .note_evt(note_evt), .evt_voice(evt_voice), .framing_err(framing_err));

    midi_poly_rx #(.INPUT_CLOCK_FREQ(FREQ), .BAUD_RATE(BAUD), .NUM_VOICES(N), .VEL_BITS(VB),
                   .MIDI_CHANNEL(0), .OMNI(1)) dut_omni (
        .clk(clk), .rst(rst), .data_in(data_in), .on_out(o_on_out), .velocity_out(o_velocity_out),
        .note_out(o_note_out), .note_evt(o_note_evt), .evt_voice(o_evt_voice), .framing_err(o_framing_err));

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int ev_cnt = 0, ev_last = 0, fe_cnt = 0;

    // Event monitor on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (note_evt) begin ev_cnt++; ev_last = int'(evt_voice); end
            if (framing_err) fe_cnt++;
        end
    end

    // Reference model state
    bit m_on[N], m_held[N], m_sus;
    int m_note[N], m_vel[N], m_age[N];
    int m_status, m_idx, m_d1;
    bit x_evt;
    int x_voice;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_on[i] = 0; m_held[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0;
        end
        m_sus = 0; m_status = -1; m_idx = 0; m_d1 = 0; x_evt = 0; x_voice = 0;
    endtask

    task automatic model_note_on(input int n, input int v);
        int t; bit any_held;
        t = -1;
        for (int i = 0; i < N; i++) if (t < 0 && m_on[i] && m_note[i] == n) t = i;
        for (int i = 0; i < N; i++) if (t < 0 && !m_on[i]) t = i;
        if (t < 0) begin
            any_held = 0;
            for (int i = 0; i < N; i++) if (m_held[i]) any_held = 1;
            for (int i = 0; i < N; i++)
                if (!(any_held && !m_held[i]) && (t < 0 || m_age[i] > m_age[t])) t = i;
        end
        for (int i = 0; i < N; i++)
            if (i != t && m_on[i] && m_age[i] < N - 1) m_age[i]++;
        m_on[t] = 1; m_held[t] = 0; m_note[t] = n; m_age[t] = 0;
        m_vel[t] = v >> (7 - VB);
        if (m_vel[t] == 0) m_vel[t] = 1;
        x_evt = 1; x_voice = t;
    endtask

    task automatic model_byte(input int b);
        int kind, d2;
        x_evt = 0;
        if (b >= 'hF8) return;
        if (b >= 'hF0) begin m_status = -1; return; end
        if (b >= 'h80) begin m_status = b; m_idx = 0; return; end
        if (m_status < 0) return;
        kind = m_status >> 4;
        if (kind == 'hC || kind == 'hD) return;
        if (m_idx == 0) begin m_d1 = b; m_idx = 1; return; end
        m_idx = 0; d2 = b;
        if ((m_status & 15) != 0) return;
        if (kind == 9 && d2 > 0) model_note_on(m_d1, d2);
        else if (kind == 8 || kind == 9) begin
            for (int i = N - 1; i >= 0; i--)
                if (m_on[i] && m_note[i] == m_d1) begin x_evt = 1; x_voice = i; end
            for (int i = 0; i < N; i++)
                if (m_on[i] && m_note[i] == m_d1) begin
                    if (m_sus) m_held[i] = 1; else m_on[i] = 0;
                end
        end else if (kind == 'hB && m_d1 == 123) begin
            for (int i = N - 1; i >= 0; i--) if (m_on[i]) begin x_evt = 1; x_voice = i; end
            for (int i = 0; i < N; i++) begin m_on[i] = 0; m_held[i] = 0; end
        end else if (kind == 'hB && m_d1 == 64 && SUS) begin
            m_sus = (d2 >= 64);
            if (!m_sus) begin
                for (int i = N - 1; i >= 0; i--) if (m_held[i]) begin x_evt = 1; x_voice = i; end
                for (int i = 0; i < N; i++) if (m_held[i]) begin m_on[i] = 0; m_held[i] = 0; end
            end
        end
    endtask

    function automatic logic [N-1:0] exp_on();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = m_on[i];
        return r;
    endfunction

    function automatic logic [N*7-1:0] exp_note();
        logic [N*7-1:0] r;
        for (int i = 0; i < N; i++) r[i*7 +: 7] = 7'(m_note[i]);
        return r;
    endfunction

    function automatic logic [N*VB-1:0] exp_vel();
        logic [N*VB-1:0] r;
        for (int i = 0; i < N; i++) r[i*VB +: VB] = VB'(m_vel[i]);
        return r;
    endfunction

    // Serial frame: start bit, 8 data bits LSB first, stop bit (optionally forced low), idle gap
    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        logic [8:0] frame;
        frame = {b, 1'b0};
        for (int k = 0; k < 9; k++) begin
            data_in = frame[k];
            repeat (BP) @(negedge clk);
        end
        if (good_stop) begin
            data_in = 1'b1;
            repeat (BP) @(negedge clk);
        end else begin
            data_in = 1'b0;
            repeat (BP / 2 + 4) @(negedge clk);
            data_in = 1'b1;
            repeat (BP / 2 - 4) @(negedge clk);
        end
        repeat (2 * BP) @(negedge clk);
    endtask

    task automatic tx(input logic [7:0] b);
        send_byte(b, 1'b1);
        model_byte(int'(b));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({on_out, note_out, velocity_out, note_evt, evt_voice, framing_err} !== '0) begin
            fails++; $display("FAIL reset_outputs: got on=%h note=%h vel=%h expected all zero", on_out, note_out, velocity_out);
        end
        tests++;
        if ({o_on_out, o_note_out, o_velocity_out, o_note_evt, o_evt_voice, o_framing_err} !== '0) begin
            fails++; $display("FAIL reset_omni: got on=%h expected 0", o_on_out);
        end
        do_reset();
    endtask

    task automatic test_single_note();
        int e0;
        do_reset(); e0 = ev_cnt;
        tx(8'h90); tx(8'h3C); tx(8'h7F);
        tests++;
        if (on_out !== 8'h01) begin fails++; $display("FAIL single_on: got %h expected 01", on_out); end
        tests++;
        if (note_out[6:0] !== 7'h3C || velocity_out[2:0] !== 3'd7) begin
            fails++; $display("FAIL single_note_vel: got note %h vel %0d expected 3c 7", note_out[6:0], velocity_out[2:0]);
        end
        tests++;
        if (ev_cnt - e0 !== 1 || ev_last !== 0) begin
            fails++; $display("FAIL single_evt: got %0d events last %0d expected 1 events voice 0", ev_cnt - e0, ev_last);
        end
    endtask

    task automatic test_running_status();
        int e0;
        do_reset(); e0 = ev_cnt;
        tx(8'h90); tx(8'h3C); tx(8'h40); tx(8'h3E); tx(8'h40); tx(8'h3C); tx(8'h00);
        tests++;
        if (on_out !== 8'h02) begin fails++; $display("FAIL running_on: got %h expected 02", on_out); end
        tests++;
        if (note_out[6:0] !== 7'h3C || note_out[13:7] !== 7'h3E || velocity_out[2:0] !== 3'd4) begin
            fails++; $display("FAIL running_hold: got notes %h %h vel %0d expected 3c 3e 4", note_out[6:0], note_out[13:7], velocity_out[2:0]);
        end
        tests++;
        if (ev_cnt - e0 !== 3 || ev_last !== 0) begin
            fails++; $display("FAIL running_evt: got %0d last %0d expected 3 last 0", ev_cnt - e0, ev_last);
        end
    endtask

    task automatic test_steal();
        do_reset();
        tx(8'h90);
        for (int k = 0; k < 9; k++) begin tx(8'(8'h40 + k)); tx(8'h7F); end
        tests++;
        if (on_out !== 8'hFF) begin fails++; $display("FAIL steal_on: got %h expected ff", on_out); end
        tests++;
        if (note_out[6:0] !== 7'h48 || note_out[13:7] !== 7'h41 || ev_last !== 0) begin
            fails++; $display("FAIL steal_slot: got v0 %h v1 %h evt %0d expected 48 41 0", note_out[6:0], note_out[13:7], ev_last);
        end
    endtask

    task automatic test_realtime();
        do_reset();
        tx(8'h90); tx(8'h3C); tx(8'hF8); tx(8'h50);
        tests++;
        if (on_out !== 8'h01 || note_out[6:0] !== 7'h3C || velocity_out[2:0] !== 3'd5) begin
            fails++; $display("FAIL realtime: got on %h note %h vel %0d expected 01 3c 5", on_out, note_out[6:0], velocity_out[2:0]);
        end
        tx(8'h3E); tx(8'h01);
        tests++;
        if (on_out !== 8'h03 || velocity_out[5:3] !== 3'd1) begin
            fails++; $display("FAIL vel_floor: got on %h vel %0d expected 03 1", on_out, velocity_out[5:3]);
        end
    endtask

    task automatic test_channel();
        int e0;
        do_reset(); e0 = ev_cnt;
        tx(8'h92); tx(8'h3C); tx(8'h7F);
        tests++;
        if (on_out !== 8'h00 || ev_cnt - e0 !== 0) begin
            fails++; $display("FAIL chan_filter: got on %h events %0d expected 00 0", on_out, ev_cnt - e0);
        end
        tests++;
        if (o_on_out !== 8'h01 || o_note_out[6:0] !== 7'h3C) begin
            fails++; $display("FAIL chan_omni: got on %h note %h expected 01 3c", o_on_out, o_note_out[6:0]);
        end
    endtask

    task automatic test_framing();
        int e0, f0;
        do_reset();
        tx(8'h90); tx(8'h3C); tx(8'h7F);
        e0 = ev_cnt; f0 = fe_cnt;
        send_byte(8'h80, 1'b0);
        tests++;
        if (fe_cnt - f0 !== 1) begin fails++; $display("FAIL framing_pulse: got %0d expected 1", fe_cnt - f0); end
        tests++;
        if (on_out !== 8'h01 || ev_cnt - e0 !== 0) begin
            fails++; $display("FAIL framing_nochange: got on %h events %0d expected 01 0", on_out, ev_cnt - e0);
        end
        tx(8'h3E); tx(8'h7F);
        tests++;
        if (on_out !== 8'h03) begin fails++; $display("FAIL framing_status_kept: got %h expected 03", on_out); end
        e0 = ev_cnt;
        tx(8'h80); tx(8'h50); tx(8'h00);
        tests++;
        if (on_out !== 8'h03 || ev_cnt - e0 !== 0) begin
            fails++; $display("FAIL off_nomatch: got on %h events %0d expected 03 0", on_out, ev_cnt - e0);
        end
    endtask

    task automatic test_all_notes_off();
        do_reset();
        tx(8'h90); tx(8'h3C); tx(8'h7F); tx(8'h3E); tx(8'h7F);
        tx(8'hB0); tx(8'h7B); tx(8'h00);
        tests++;
        if (on_out !== 8'h00 || note_out[13:0] !== {7'h3E, 7'h3C}) begin
            fails++; $display("FAIL all_off: got on %h notes %h expected 00 %h", on_out, note_out[13:0], {7'h3E, 7'h3C});
        end
    endtask

`ifdef SUSTAIN_EN
    task automatic test_sustain();
        do_reset();
        tx(8'h90); tx(8'h3C); tx(8'h7F);
        tx(8'hB0); tx(8'h40); tx(8'h7F);
        tx(8'h80); tx(8'h3C); tx(8'h00);
        tests++;
        if (on_out !== 8'h01) begin fails++; $display("FAIL sustain_hold: got %h expected 01", on_out); end
        tx(8'hB0); tx(8'h40); tx(8'h00);
        tests++;
        if (on_out !== 8'h00) begin fails++; $display("FAIL sustain_release: got %h expected 00", on_out); end
    endtask
`endif

    task automatic test_random();
        logic [7:0] stat_tbl [6];
        logic [7:0] b;
        int r, s, e0;
        stat_tbl[0] = 8'h90; stat_tbl[1] = 8'h80; stat_tbl[2] = 8'hB0;
        stat_tbl[3] = 8'h91; stat_tbl[4] = 8'hC0; stat_tbl[5] = 8'h90;
        do_reset();
        tx(8'h90);
        for (int k = 0; k < 110; k++) begin
            r = $urandom_range(0, 19);
            if (r < 3)       b = stat_tbl[$urandom_range(0, 5)];
            else if (r == 3) b = 8'hF8;
            else if (r == 4) b = 8'hF1;
            else begin
                s = $urandom_range(0, 9);
                if (s < 2)       b = 8'h00;
                else if (s == 2) b = 8'h7B;
                else if (s == 3) b = 8'h40;
                else             b = 8'(8'h3C + $urandom_range(0, 9));
            end
            e0 = ev_cnt;
            tx(b);
            tests++;
            if (on_out !== exp_on() || note_out !== exp_note() || velocity_out !== exp_vel()) begin
                fails++; $display("FAIL rand_state byte %0d (%h): got on %h note %h vel %h expected on %h note %h vel %h",
                                  k, b, on_out, note_out, velocity_out, exp_on(), exp_note(), exp_vel());
            end
            tests++;
            if ((ev_cnt - e0) !== int'(x_evt) || (x_evt && ev_last !== x_voice)) begin
                fails++; $display("FAIL rand_evt byte %0d (%h): got %0d events voice %0d expected %0d voice %0d",
                                  k, b, ev_cnt - e0, ev_last, x_evt, x_voice);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_note();
        test_running_status();
        test_steal();
        test_realtime();
        test_channel();
        test_framing();
        test_all_notes_off();
`ifdef SUSTAIN_EN
        test_sustain();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
